// File: rtl/request_queue_pkg.sv
// Shared types and constants for the memory-request queue downstream of the trace parser.
package request_queue_pkg;

   localparam int ADDRESS_WIDTH = 32;
   localparam int QUEUE_DEPTH   = 16;

   typedef logic [31:0] int_t;
   localparam int_t INT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      NOP   = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } parsed_op_t;

   typedef struct packed {
      parsed_op_t               opcode;
      logic [ADDRESS_WIDTH-1:0] address;
      int_t                     time_cpu;
      logic                     op_ready_s;
   } parser_out_struct_t;

   typedef struct packed {
      parsed_op_t               opcode;
      logic [ADDRESS_WIDTH-1:0] address;
      int_t                     time_cpu;
   } queue_entry_t;

   typedef enum logic [1:0] {
      H_IDLE       = 2'd0,
      H_WAIT_TIME  = 2'd1,
      H_WAIT_SPACE = 2'd2
   } queue_hold_states_t;

   // Strips the handshake bit so a parser output can be stored or compared as a queue entry.
   function automatic queue_entry_t to_entry(input parser_out_struct_t p);
      queue_entry_t e;
      e.opcode   = p.opcode;
      e.address  = p.address;
      e.time_cpu = p.time_cpu;
      return e;
   endfunction

endpackage

// File: rtl/request_queue_fifo.sv
// Circular request buffer; full/empty derive from a registered occupancy count.
module request_fifo
   import request_queue_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enq,
   input  queue_entry_t                 enq_data,
   input  logic                         deq,
   output queue_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   queue_entry_t     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_r;
   logic             empty_r;
   logic             do_enq_s;
   logic             do_deq_s;
   logic [CNT_W-1:0] count_next_s;

   // Qualify requests against current occupancy and work out the next count.
   always_comb begin
      do_enq_s     = enq & ~full_r;
      do_deq_s     = deq & ~empty_r;
      count_next_s = count_r;
      if (do_enq_s && !do_deq_s) begin
         count_next_s = count_r + CNT_W'(1);
      end else if (!do_enq_s && do_deq_s) begin
         count_next_s = count_r - CNT_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (do_enq_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (do_deq_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         count_r <= count_next_s;
         full_r  <= (count_next_s == CNT_W'(DEPTH));
         empty_r <= (count_next_s == CNT_W'(0));
      end
   end

   // Storage needs no reset: the head output is masked while empty.
   always_ff @(posedge clk) begin
      if (do_enq_s) mem_r[wr_ptr_r] <= enq_data;
   end

   // Present the oldest entry, or zero when nothing is stored.
   always_comb begin
      if (empty_r) begin
         head = '0;
      end else begin
         head = mem_r[rd_ptr_r];
      end
   end

   assign count = count_r;
   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/request_queue.sv
// Memory-request queue: captures parser entries, releases them at their CPU time, owns queue_time.
module request_queue
   import request_queue_pkg::*;
#(
   parameter int QUEUE_DEPTH = request_queue_pkg::QUEUE_DEPTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  parser_out_struct_t                 parser_out,
   output int_t                               queue_time,
   output logic                               queue_full,
   output logic                               pending_request,
   input  logic                               deq_ready,
   output logic                               deq_valid,
   output queue_entry_t                       head,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count
);

   queue_hold_states_t state_r;
   queue_entry_t       hold_r;
   queue_entry_t       last_r;
   queue_entry_t       in_entry_s;
   int_t               queue_time_r;
   logic               pending_r;
   logic               new_entry_s;
   logic               time_reached_s;
   logic               skip_s;
   logic               enq_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;

   // Detect a fresh trace line and decide whether the held entry can enter the FIFO now.
   always_comb begin
      in_entry_s     = to_entry(parser_out);
      new_entry_s    = parser_out.op_ready_s && (parser_out.opcode != NOP) &&
                       (state_r == H_IDLE) && (in_entry_s != last_r);
      time_reached_s = (queue_time_r >= hold_r.time_cpu);
      skip_s         = fifo_empty_s && (state_r == H_WAIT_TIME) &&
                       ({1'b0, hold_r.time_cpu} > ({1'b0, queue_time_r} + 33'd1));
      case (state_r)
         H_WAIT_TIME:  enq_s = time_reached_s && !fifo_full_s;
         H_WAIT_SPACE: enq_s = !fifo_full_s;
         default:      enq_s = 1'b0;
      endcase
   end

   // Hold FSM with registered pending flag, tuple capture and the simulation clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= H_IDLE;
         pending_r    <= 1'b0;
         hold_r       <= '0;
         last_r       <= '0;
         queue_time_r <= '0;
      end else begin
         case (state_r)
            H_IDLE: begin
               if (new_entry_s) begin
                  hold_r    <= in_entry_s;
                  last_r    <= in_entry_s;
                  state_r   <= H_WAIT_TIME;
                  pending_r <= 1'b1;
               end
            end
            H_WAIT_TIME: begin
               if (time_reached_s && fifo_full_s) begin
                  state_r <= H_WAIT_SPACE;
               end else if (time_reached_s) begin
                  state_r   <= H_IDLE;
                  pending_r <= 1'b0;
               end
            end
            H_WAIT_SPACE: begin
               if (!fifo_full_s) begin
                  state_r   <= H_IDLE;
                  pending_r <= 1'b0;
               end
            end
            default: begin
               state_r   <= H_IDLE;
               pending_r <= 1'b0;
            end
         endcase

         if (skip_s) begin
            queue_time_r <= hold_r.time_cpu;
         end else if (queue_time_r != INT_MAX) begin
            queue_time_r <= queue_time_r + 32'd1;
         end
      end
   end

   request_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .enq      (enq_s),
      .enq_data (hold_r),
      .deq      (deq_ready),
      .head     (head),
      .count    (count),
      .full     (fifo_full_s),
      .empty    (fifo_empty_s)
   );

   assign queue_time      = queue_time_r;
   assign pending_request = pending_r;
   assign queue_full      = fifo_full_s;
   assign deq_valid       = ~fifo_empty_s;

endmodule

// File: doc/request_queue.md
# request_queue

Memory-request queue directly downstream of the trace parser. Each cycle it samples the parser's output struct and captures every new trace entry into a one-entry hold register. It enqueues the entry into a 16-deep circular FIFO once simulation time reaches the entry's CPU time. It owns the simulation clock `queue_time` and returns `queue_time`, `queue_full` and `pending_request` to the parser; the DRAM scheduler pops requests from the FIFO head.

## Interface
- `QUEUE_DEPTH`, default 16: FIFO entries; power of two, at least 2.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `parser_out`  in  `parser_out_struct_t`: parser output; fields `opcode`, `address`, `time_cpu`, `op_ready_s`.
- `queue_time`  out  `int_t`: current simulation time in CPU clocks.
- `queue_full`  out  1: FIFO holds `QUEUE_DEPTH` entries.
- `pending_request`  out  1: the hold register holds an entry not yet enqueued.
- `deq_ready`  in  1: scheduler pops the head this cycle.
- `deq_valid`  out  1: FIFO non-empty.
- `head`  out  `queue_entry_t`: oldest entry (`opcode`, `address`, `time_cpu`).
- `count`  out  `$clog2(QUEUE_DEPTH+1)`: current occupancy.

## Operation
- **New-entry detection.** An entry is new when all of these hold: `op_ready_s`=1, `opcode`≠NOP, hold FSM in H_IDLE, and `{opcode,address,time_cpu}` differs from the last captured tuple.
  - Identical consecutive trace lines are collapsed into one entry. This is decided behaviour.
- **Capture.** A new entry is captured into `hold` and recorded as the last captured tuple.
- **Hold FSM** (3 states):
  - H_IDLE → H_WAIT_TIME on capture.
  - H_WAIT_TIME → H_WAIT_SPACE when `queue_time` ≥ `hold.time_cpu` and `queue_full`=1.
  - H_WAIT_TIME → H_IDLE (enqueue) when `queue_time` ≥ `hold.time_cpu` and `queue_full`=0.
  - H_WAIT_SPACE → H_IDLE (enqueue) when `queue_full`=0.
- **`pending_request`** is registered: it is 1 exactly when the FSM is not in H_IDLE.
- **Enqueue** writes at `wr_ptr`, then increments `wr_ptr` modulo `QUEUE_DEPTH`.
- **Dequeue** happens when `deq_ready`=1 and `deq_valid`=1: `rd_ptr` increments modulo depth. `deq_ready` while empty is ignored.
- **Simultaneous enqueue and dequeue:** `count` unchanged, both pointers advance.
- **Full:** `queue_full`=1 blocks enqueue even if a dequeue happens in the same cycle. The blocked enqueue takes place in the following cycle.
- **Time update**, every cycle:
  - If the FIFO is empty, the FSM is in H_WAIT_TIME and `hold.time_cpu` > `queue_time`+1: `queue_time` ← `hold.time_cpu` (idle skip).
  - Otherwise `queue_time` ← `queue_time`+1, saturating at the `int_t` maximum.
- **Pointer width:** `$clog2(QUEUE_DEPTH)`. Full/empty are derived from `count`, never from pointer equality.

## Timing
- **Reset values:**
  - Outputs: `queue_time`=0, `queue_full`=0, `pending_request`=0, `deq_valid`=0, `head`=0, `count`=0.
  - Internal: pointers 0, FSM H_IDLE, last tuple = {NOP,0,0}.
- **Reset mid-operation:** all FIFO and hold contents are discarded immediately (asynchronous). No entry survives.
- **Capture latency:** entry seen in cycle N → `pending_request`=1 in N+1.
- **Enqueue latency:** enqueue edge at the end of cycle M → `count` and `deq_valid` updated in M+1. `head` is valid in the same cycle as `deq_valid`.
- **Idle skip:** capture in N; `queue_time` jumps in N+1; enqueue at the end of N+2.
- **`queue_full`, `count`, `deq_valid`** are all registered and change only on clock edges.
- **Parser interface:** no combinational path from `parser_out` to any output. This avoids a loop through the parser's `pending_request`-dependent `op_ready_s`.

## Structure
- **Additions to `global_defs`:**
  - `queue_entry_t` packed struct (`opcode`: `parsed_op_t`; `address`: `ADDRESS_WIDTH` bits; `time_cpu`: `int_t`).
  - `queue_hold_states_t` enum {H_IDLE, H_WAIT_TIME, H_WAIT_SPACE}.
  - `QUEUE_DEPTH` constant.
- **Sub-module `request_fifo`:**
  - Parameterised circular buffer.
  - Ports: `enq`, `enq_data`, `deq`, `head`, `count`, `full`, `empty`.
- **Top (`request_queue`):** holds the hold FSM, tuple compare and time counter.

## Test plan
- Single entry {READ, 0x1F00, t=5} at reset exit → `pending_request`=1 next cycle; `queue_time` jumps 1→5; `count`=1; `head.address`=0x1F00.
- 17 entries all t=0, `deq_ready`=0 → `queue_full`=1 after the 16th, 17th held with `pending_request`=1; pulse `deq_ready` once → 17th enqueued one cycle after `queue_full` drops; `count`=16.
- 40 entries t=0..39 with `deq_ready`=1 every other cycle → pops in trace order with no loss across pointer wrap; final `count` and `deq_valid` are 0 after draining.
- `count`=3 with simultaneous enqueue and dequeue → `count` stays 3; `head` advances to the second-oldest entry.
- Parser holds {WRITE, 0x40, t=2} for 6 cycles, then a NOP output → exactly one enqueue; NOP ignored.
- Assert `rst` with `count`=5 and FSM in H_WAIT_TIME → all outputs at reset values in the same cycle; next post-reset entry enqueued normally.
